// File: rtl/seq_sub_pkg.sv
// -----------------------------------------------------------------------------
// seq_sub_pkg
// Shared declarations for the digit-serial subtractor.
//   state_t     : controller states IDLE -> RUN -> DONE -> IDLE
//   digit_count : number of W-bit digits in an N-bit operand
// -----------------------------------------------------------------------------
package seq_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int digit_count(input int n, input int w);
      return n / w;
   endfunction

endpackage

// File: rtl/digit_subtractor.sv
// -----------------------------------------------------------------------------
// digit_subtractor
// Combinational W-bit ripple-borrow subtractor slice: d = x - y - bin.
// Ports:
//   x    [W-1:0] in  : minuend digit
//   y    [W-1:0] in  : subtrahend digit
//   bin          in  : borrow into the least significant bit
//   d    [W-1:0] out : difference digit
//   bout         out : borrow out of the most significant bit
// -----------------------------------------------------------------------------
module digit_subtractor #(
   parameter int W = 2
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         bin,
   output logic [W-1:0] d,
   output logic         bout
);

   logic [W:0] w_b;

   assign w_b[0] = bin;

   generate
      for (genvar gi = 0; gi < W; gi++) begin : g_bit
         assign d[gi] = x[gi] ^ y[gi] ^ w_b[gi];
         // Borrow when y exceeds x, or when they are equal and a borrow arrives.
         assign w_b[gi+1] = (~x[gi] & y[gi]) | (~(x[gi] ^ y[gi]) & w_b[gi]);
      end
   endgenerate

   assign bout = w_b[W];

endmodule

// File: rtl/seq_subtractor.sv
// -----------------------------------------------------------------------------
// seq_subtractor
// Digit-serial N-bit subtractor: computes a - b one W-bit digit per cycle,
// LSB digit first, with valid/ready handshakes on both sides.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operand handshake (ready only when idle)
//   a, b     [N-1:0]  : minuend, subtrahend
//   out_valid/out_ready : result handshake (result held until accepted)
//   diff     [N-1:0]  : a - b (wrapped, or saturated when enabled)
//   borrow_out        : unsigned borrow (a < b)
//   overflow          : two's-complement overflow
//   zero              : diff == 0
// Build option:
//   SEQ_SUB_SATURATE_EN : clamp diff to the signed max/min on overflow.
// -----------------------------------------------------------------------------
module seq_subtractor
   import seq_sub_pkg::*;
#(
   parameter int N = 8,
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] diff,
   output logic         borrow_out,
   output logic         overflow,
   output logic         zero
);

   localparam int D  = digit_count(N, W);
   localparam int CW = (D > 1) ? $clog2(D) : 1;
   localparam logic [CW-1:0] LAST_DIGIT = CW'(D - 1);

   generate
      if ((W < 1) || ((N % W) != 0)) begin : g_bad_params
         $error("seq_subtractor: W must be >= 1 and divide N");
      end
   endgenerate

   state_t        r_state;
   logic [N-1:0]  r_a;        // remaining minuend digits, current digit in LSBs
   logic [N-1:0]  r_b;        // remaining subtrahend digits
   logic [N-1:0]  r_acc;      // difference digits, filled from the top down
   logic          r_borrow;
   logic [CW-1:0] r_cnt;
   logic          r_a_msb;
   logic          r_b_msb;
   logic [N-1:0]  r_diff;
   logic          r_borrow_out;
   logic          r_overflow;
   logic          r_zero;
   logic          r_out_valid;

   logic [W-1:0]  w_d;
   logic          w_bout;
   logic [N-1:0]  w_raw;
   logic          w_ovf;
   logic [N-1:0]  w_final;

   digit_subtractor #(.W(W)) u_digit (
      .x    (r_a[W-1:0]),
      .y    (r_b[W-1:0]),
      .bin  (r_borrow),
      .d    (w_d),
      .bout (w_bout)
   );

   // After the last digit the newest digit lands in the top W bits, so w_raw
   // holds the complete wrapped difference on the final RUN cycle.
   generate
      if (W == N) begin : g_single
         assign w_raw = w_d;
      end else begin : g_multi
         assign w_raw = {w_d, r_acc[N-1:W]};
      end
   endgenerate

   assign w_ovf = (r_a_msb != r_b_msb) && (w_raw[N-1] != r_a_msb);

`ifdef SEQ_SUB_SATURATE_EN
   // Negative minus positive overflowing clamps to min, the converse to max.
   assign w_final = !w_ovf ? w_raw :
                    r_a_msb ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`else
   assign w_final = w_raw;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_a          <= '0;
         r_b          <= '0;
         r_acc        <= '0;
         r_borrow     <= 1'b0;
         r_cnt        <= '0;
         r_a_msb      <= 1'b0;
         r_b_msb      <= 1'b0;
         r_diff       <= '0;
         r_borrow_out <= 1'b0;
         r_overflow   <= 1'b0;
         r_zero       <= 1'b0;
         r_out_valid  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_a_msb  <= a[N-1];
                  r_b_msb  <= b[N-1];
                  r_acc    <= '0;
                  r_borrow <= 1'b0;
                  r_cnt    <= '0;
                  r_state  <= RUN;
               end
            end
            RUN: begin
               r_a      <= r_a >> W;
               r_b      <= r_b >> W;
               r_acc    <= w_raw;
               r_borrow <= w_bout;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == LAST_DIGIT) begin
                  r_diff       <= w_final;
                  r_borrow_out <= w_bout;
                  r_overflow   <= w_ovf;
                  r_zero       <= (w_final == '0);
                  r_out_valid  <= 1'b1;
                  r_state      <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready   = (r_state == IDLE);
   assign out_valid  = r_out_valid;
   assign diff       = r_diff;
   assign borrow_out = r_borrow_out;
   assign overflow   = r_overflow;
   assign zero       = r_zero;

endmodule

// File: tb/tb_seq_subtractor.sv
module tb_seq_subtractor;

   localparam int N = 8;
   localparam int W = 2;
   localparam int D = N / W;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] diff;
   logic         borrow_out;
   logic         overflow;
   logic         zero;

   int checks = 0;
   int errors = 0;

   logic [N-1:0] exp_diff;
   logic         exp_borrow;
   logic         exp_ovf;
   logic         exp_zero;
   logic         exp_pending = 1'b0;

   seq_subtractor #(.N(N), .W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .diff       (diff),
      .borrow_out (borrow_out),
      .overflow   (overflow),
      .zero       (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   task automatic model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                        output logic [N-1:0] md, output logic mbo,
                        output logic mov, output logic mz);
      int ua, ub, sa, sb, sd;
      ua  = int'(ma);
      ub  = int'(mb);
      sa  = ua >= (1 << (N-1)) ? ua - (1 << N) : ua;
      sb  = ub >= (1 << (N-1)) ? ub - (1 << N) : ub;
      sd  = sa - sb;
      mbo = (ua < ub);
      mov = (sd > (1 << (N-1)) - 1) || (sd < -(1 << (N-1)));
      md  = N'((ua - ub + (1 << N)) % (1 << N));
`ifdef SEQ_SUB_SATURATE_EN
      if (mov) md = (sa < 0) ? N'(1 << (N-1)) : N'((1 << (N-1)) - 1);
`endif
      mz  = (md == '0);
   endtask

   // Compare process: every cycle a result is presented it must match the model.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (!exp_pending) begin
            check("spurious_out_valid", 32'(out_valid), 32'd0);
         end else begin
            check("diff", 32'(diff), 32'(exp_diff));
            check("borrow_out", 32'(borrow_out), 32'(exp_borrow));
            check("overflow", 32'(overflow), 32'(exp_ovf));
            check("zero", 32'(zero), 32'(exp_zero));
            check("in_ready_in_done", 32'(in_ready), 32'd0);
         end
      end
   end

   task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input int hold,
                         output logic [N-1:0] rd, output logic rbo, output logic rov,
                         output logic rz, output int lat);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("in_ready_wait", 32'(in_ready), 32'd1);
      model(ta, tb, exp_diff, exp_borrow, exp_ovf, exp_zero);
      exp_pending = 1'b1;
      a = ta;
      b = tb;
      in_valid = 1'b1;
      @(posedge clk); #1;
      // Garbage on the operand inputs while busy must be ignored.
      lat = 0;
      while (!out_valid && lat < 50) begin
         a = N'($urandom);
         b = N'($urandom);
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      check("out_valid_wait", 32'(out_valid), 32'd1);
      rd  = diff;
      rbo = borrow_out;
      rov = overflow;
      rz  = zero;
      repeat (hold) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      exp_pending = 1'b0;
      check("release_out_valid", 32'(out_valid), 32'd0);
      check("release_in_ready", 32'(in_ready), 32'd1);
      $display("op a=0x%02h b=0x%02h -> diff=0x%02h borrow=%0b ovf=%0b zero=%0b lat=%0d hold=%0d",
               ta, tb, rd, rbo, rov, rz, lat, hold);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] rd;
      logic rbo, rov, rz;
      int lat;
      int seen;

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_diff", 32'(diff), 32'd0);
      check("reset_flags", 32'({borrow_out, overflow, zero}), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("reset_in_ready", 32'(in_ready), 32'd1);

      run_op(8'h05, 8'h03, 0, rd, rbo, rov, rz, lat);
      check("lit_05_03_diff", 32'(rd), 32'h02);
      check("lit_05_03_flags", 32'({rbo, rov, rz}), 32'd0);
      check("lit_05_03_latency", 32'(lat), 32'd4);

      run_op(8'h03, 8'h05, 1, rd, rbo, rov, rz, lat);
      check("lit_03_05_diff", 32'(rd), 32'hFE);
      check("lit_03_05_borrow", 32'(rbo), 32'd1);
      check("lit_03_05_ovf", 32'(rov), 32'd0);

      run_op(8'h80, 8'h01, 0, rd, rbo, rov, rz, lat);
`ifdef SEQ_SUB_SATURATE_EN
      check("lit_80_01_diff", 32'(rd), 32'h80);
`else
      check("lit_80_01_diff", 32'(rd), 32'h7F);
`endif
      check("lit_80_01_ovf", 32'(rov), 32'd1);
      check("lit_80_01_borrow", 32'(rbo), 32'd0);

      run_op(8'h7F, 8'hFF, 2, rd, rbo, rov, rz, lat);
`ifdef SEQ_SUB_SATURATE_EN
      check("lit_7F_FF_diff", 32'(rd), 32'h7F);
`else
      check("lit_7F_FF_diff", 32'(rd), 32'h80);
`endif
      check("lit_7F_FF_ovf", 32'(rov), 32'd1);
      check("lit_7F_FF_borrow", 32'(rbo), 32'd1);

      run_op(8'h5A, 8'h5A, 3, rd, rbo, rov, rz, lat);
      check("lit_5A_5A_diff", 32'(rd), 32'h00);
      check("lit_5A_5A_zero", 32'(rz), 32'd1);

      // Reset during the second RUN cycle discards the operation.
      a = 8'h33;
      b = 8'h11;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
      check("midrun_rst_diff", 32'(diff), 32'd0);
      check("midrun_rst_flags", 32'({borrow_out, overflow, zero}), 32'd0);
      check("midrun_rst_in_ready", 32'(in_ready), 32'd1);
      seen = 0;
      repeat (D + 3) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("midrun_rst_no_result", 32'(seen), 32'd0);
      $display("reset in RUN: out_valid seen %0d times afterwards", seen);

      run_op(8'h10, 8'h01, 0, rd, rbo, rov, rz, lat);
      check("lit_10_01_diff", 32'(rd), 32'h0F);

      for (int i = 0; i < 40; i++) begin
         run_op(N'($urandom), N'($urandom), int'($urandom_range(0, 3)), rd, rbo, rov, rz, lat);
         check("rand_latency", 32'(lat), 32'(D));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
